// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: launches the iterative multiplier or divider engine on a
// one-cycle start command. It waits for the engine's done flag, with a bounded
// wait, then strobes the HI/LO registers and returns a single done pulse.
// Divide-by-zero is caught before the divider is ever launched.
//
// state    | meaning
// ---------+-----------------------------------------------------------------
// IDLE     | waiting for start_mult / start_div
// M_LAUNCH | one-cycle mult_start pulse, wait counter cleared
// M_WAIT   | waiting for mult_done, counting toward timeout
// D_LAUNCH | one-cycle div_start pulse, wait counter cleared
// D_WAIT   | waiting for div_done, counting toward timeout
// WB       | hi_write/lo_write strobe, source chosen by the captured op type
// FIN      | done pulse after a normal writeback
// DZ       | done + div_zero, divisor was zero, nothing launched or written
// TO       | done + timeout, engine never answered, nothing written
module muldiv_sequencer #(
  parameter  int MAX_WAIT = 64,
  localparam int CW       = $clog2(MAX_WAIT + 1)
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start_mult,
  input  logic        start_div,
  input  logic [31:0] divisor,
  output logic        mult_start,
  input  logic        mult_done,
  output logic        div_start,
  input  logic        div_done,
  output logic        hilo_sel,
  output logic        hi_write,
  output logic        lo_write,
  output logic        busy,
  output logic        done,
  output logic        div_zero,
  output logic        timeout
);

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    M_LAUNCH = 4'd1,
    M_WAIT   = 4'd2,
    D_LAUNCH = 4'd3,
    D_WAIT   = 4'd4,
    WB       = 4'd5,
    FIN      = 4'd6,
    DZ       = 4'd7,
    TO       = 4'd8
  } seqState_t;

  localparam logic [CW-1:0] LAST_WAIT = CW'(MAX_WAIT - 1);

  seqState_t     state;
  seqState_t     nextState;
  logic [CW-1:0] waitCnt;
  logic [CW-1:0] nextCnt;
  logic          opIsMult;
  logic          nextOpIsMult;
  logic          waitLimit;

  // The counter stops at its terminal value, and the state then moves on, so
  // the counter cannot wrap.
  assign waitLimit = (waitCnt == LAST_WAIT);

  // State, wait counter and op-type flag registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      waitCnt  <= '0;
      opIsMult <= 1'b0;
    end else begin
      state    <= nextState;
      waitCnt  <= nextCnt;
      opIsMult <= nextOpIsMult;
    end
  end

  // Next-state, counter and op-type selection
  always_comb begin
    nextState    = state;
    nextCnt      = waitCnt;
    nextOpIsMult = opIsMult;
    unique case (state)
      IDLE: begin
        // Multiply wins a simultaneous request, and the divide is dropped.
        if (start_mult) begin
          nextState    = M_LAUNCH;
          nextOpIsMult = 1'b1;
        end else if (start_div) begin
          nextOpIsMult = 1'b0;
          if (divisor == 32'd0) begin
            nextState = DZ;
          end else begin
            nextState = D_LAUNCH;
          end
        end
      end
      M_LAUNCH: begin
        nextCnt   = '0;
        nextState = M_WAIT;
      end
      D_LAUNCH: begin
        nextCnt   = '0;
        nextState = D_WAIT;
      end
      M_WAIT: begin
        if (mult_done) begin
          nextState = WB;
        end else if (waitLimit) begin
          nextState = TO;
        end else begin
          nextCnt = waitCnt + CW'(1);
        end
      end
      D_WAIT: begin
        if (div_done) begin
          nextState = WB;
        end else if (waitLimit) begin
          nextState = TO;
        end else begin
          nextCnt = waitCnt + CW'(1);
        end
      end
      WB:      nextState = FIN;
      FIN:     nextState = IDLE;
      DZ:      nextState = IDLE;
      TO:      nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Moore output decode: outputs depend only on registered state and op flag
  always_comb begin
    mult_start = 1'b0;
    div_start  = 1'b0;
    hilo_sel   = 1'b0;
    hi_write   = 1'b0;
    lo_write   = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    div_zero   = 1'b0;
    timeout    = 1'b0;
    unique case (state)
      IDLE:     busy = 1'b0;
      M_LAUNCH: begin
        mult_start = 1'b1;
        hilo_sel   = 1'b1;
      end
      M_WAIT:   hilo_sel = 1'b1;
      D_LAUNCH: div_start = 1'b1;
      D_WAIT:   ;
      WB: begin
        hi_write = 1'b1;
        lo_write = 1'b1;
        hilo_sel = opIsMult;
      end
      FIN:      done = 1'b1;
      DZ: begin
        done     = 1'b1;
        div_zero = 1'b1;
      end
      TO: begin
        done    = 1'b1;
        timeout = 1'b1;
      end
      default:  busy = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Bench for muldiv_sequencer. Each operation is scripted as a per-cycle
// timeline of expected outputs. The script is derived from the operation kind
// and the chosen engine latency, and is checked every cycle by one compare
// process. Literal latency and pulse-count expectations pin the timeline.
module tb_muldiv_sequencer;

  localparam int MAX_WAIT = 64;

  // Expected-output vector layout:
  // {mult_start, div_start, hilo_sel, hi_write, lo_write, busy, done, div_zero, timeout}
  localparam logic [8:0] E_IDLE    = 9'b000000000;
  localparam logic [8:0] E_MLAUNCH = 9'b101001000;
  localparam logic [8:0] E_MWAIT   = 9'b001001000;
  localparam logic [8:0] E_MWB     = 9'b001111000;
  localparam logic [8:0] E_DLAUNCH = 9'b010001000;
  localparam logic [8:0] E_DWAIT   = 9'b000001000;
  localparam logic [8:0] E_DWB     = 9'b000111000;
  localparam logic [8:0] E_FIN     = 9'b000001100;
  localparam logic [8:0] E_DZ      = 9'b000001110;
  localparam logic [8:0] E_TO      = 9'b000001101;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start_mult = 1'b0;
  logic        start_div = 1'b0;
  logic [31:0] divisor = 32'd0;
  logic        mult_done = 1'b0;
  logic        div_done = 1'b0;
  logic        mult_start, div_start, hilo_sel, hi_write, lo_write;
  logic        busy, done, div_zero, timeout;

  int passed = 0;
  int total  = 0;

  logic [8:0] expQ[$];

  int cyc = 0;
  int busyCnt = 0, doneCnt = 0, hiCnt = 0, divStartCnt = 0, multStartCnt = 0;
  int firstBusyCyc = 0, lastDoneCyc = 0;
  logic prevBusy = 1'b0;

  muldiv_sequencer #(.MAX_WAIT(MAX_WAIT)) dut (
    .clock(clock), .reset(reset),
    .start_mult(start_mult), .start_div(start_div), .divisor(divisor),
    .mult_start(mult_start), .mult_done(mult_done),
    .div_start(div_start), .div_done(div_done),
    .hilo_sel(hilo_sel), .hi_write(hi_write), .lo_write(lo_write),
    .busy(busy), .done(done), .div_zero(div_zero), .timeout(timeout)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic rnd(input int oneIn);
    return ($urandom % oneIn) == 0;
  endfunction

  function automatic logic [31:0] rndDivisor();
    return rnd(4) ? 32'd0 : $urandom;
  endfunction

  // One cycle of stimulus plus the outputs that must be seen during it.
  task automatic step(input logic sm, input logic sd, input logic [31:0] dv,
                      input logic md, input logic dd, input logic rs,
                      input logic [8:0] ex);
    start_mult = sm;
    start_div  = sd;
    divisor    = dv;
    mult_done  = md;
    div_done   = dd;
    reset      = rs;
    expQ.push_back(ex);
    @(posedge clock);
    #1;
  endtask

  task automatic gap();
    step(1'b0, 1'b0, rndDivisor(), rnd(3), rnd(3), 1'b0, E_IDLE);
  endtask

  // n = engine latency in WAIT cycles (0..MAX_WAIT-1), or -1 for never
  task automatic runMult(input int n, input bit both);
    step(1'b1, both ? 1'b1 : rnd(2), rndDivisor(), rnd(3), rnd(3), 1'b0, E_IDLE);
    step(rnd(3), both ? 1'b1 : rnd(3), rndDivisor(), rnd(3), rnd(3), 1'b0, E_MLAUNCH);
    for (int i = 0; i < MAX_WAIT; i++) begin
      step(rnd(5), both ? rnd(2) : rnd(5), rndDivisor(), (i == n), rnd(4), 1'b0, E_MWAIT);
      if (i == n) break;
    end
    if (n >= 0) begin
      step(rnd(3), rnd(3), rndDivisor(), rnd(3), rnd(3), 1'b0, E_MWB);
      step(rnd(3), rnd(3), rndDivisor(), rnd(3), rnd(3), 1'b0, E_FIN);
    end else begin
      step(rnd(3), rnd(3), rndDivisor(), rnd(3), rnd(3), 1'b0, E_TO);
    end
  endtask

  task automatic runDiv(input int n, input logic [31:0] dv);
    step(1'b0, 1'b1, dv, rnd(3), rnd(3), 1'b0, E_IDLE);
    step(rnd(3), rnd(3), rndDivisor(), rnd(3), rnd(3), 1'b0, E_DLAUNCH);
    for (int i = 0; i < MAX_WAIT; i++) begin
      step(rnd(5), rnd(5), rndDivisor(), rnd(4), (i == n), 1'b0, E_DWAIT);
      if (i == n) break;
    end
    if (n >= 0) begin
      step(rnd(3), rnd(3), rndDivisor(), rnd(3), rnd(3), 1'b0, E_DWB);
      step(rnd(3), rnd(3), rndDivisor(), rnd(3), rnd(3), 1'b0, E_FIN);
    end else begin
      step(rnd(3), rnd(3), rndDivisor(), rnd(3), rnd(3), 1'b0, E_TO);
    end
  endtask

  task automatic runDivZero();
    step(1'b0, 1'b1, 32'd0, rnd(3), rnd(3), 1'b0, E_IDLE);
    step(rnd(3), rnd(3), rndDivisor(), rnd(3), rnd(3), 1'b0, E_DZ);
  endtask

  // Single compare process: outputs against the scripted timeline, every cycle
  always @(negedge clock) begin
    logic [8:0] e;
    cyc++;
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      check("outputs", {mult_start, div_start, hilo_sel, hi_write, lo_write,
                        busy, done, div_zero, timeout}, {23'd0, e});
    end
    if (busy && !prevBusy) firstBusyCyc = cyc;
    if (done) begin
      doneCnt++;
      lastDoneCyc = cyc;
    end
    if (busy) busyCnt++;
    if (hi_write) hiCnt++;
    if (div_start) divStartCnt++;
    if (mult_start) multStartCnt++;
    prevBusy = busy;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0, d0, h0, ds0, ms0;
    @(posedge clock);
    #1;
    step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, E_IDLE);
    step(1'b1, 1'b1, 32'd0, 1'b1, 1'b1, 1'b1, E_IDLE);
    step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, E_IDLE);
    gap();

    // Multiply, engine answers in WAIT cycle 2+32: done in cycle 36
    b0 = busyCnt; d0 = doneCnt; h0 = hiCnt; ms0 = multStartCnt;
    runMult(32, 1'b0);
    gap();
    check("mult busy cycles", busyCnt - b0, 36);
    check("mult done pulses", doneCnt - d0, 1);
    check("mult hi writes", hiCnt - h0, 1);
    check("mult launch pulses", multStartCnt - ms0, 1);
    check("mult done cycle", lastDoneCyc - firstBusyCyc + 1, 36);

    // Divide by 7, same latency
    d0 = doneCnt; h0 = hiCnt; ds0 = divStartCnt;
    runDiv(32, 32'h00000007);
    gap();
    check("div launch pulses", divStartCnt - ds0, 1);
    check("div hi writes", hiCnt - h0, 1);
    check("div done pulses", doneCnt - d0, 1);

    // Divide by zero
    b0 = busyCnt; h0 = hiCnt; ds0 = divStartCnt;
    runDivZero();
    gap();
    check("dz busy cycles", busyCnt - b0, 1);
    check("dz launch pulses", divStartCnt - ds0, 0);
    check("dz hi writes", hiCnt - h0, 0);
    check("dz done cycle", lastDoneCyc - firstBusyCyc + 1, 1);

    // Multiply timeout, with spurious div_done noise during the wait
    h0 = hiCnt;
    runMult(-1, 1'b0);
    gap();
    check("timeout done cycle", lastDoneCyc - firstBusyCyc + 1, 2 + MAX_WAIT);
    check("timeout hi writes", hiCnt - h0, 0);

    // Latency boundaries
    runMult(0, 1'b0);
    runDiv(MAX_WAIT - 1, 32'h1);
    runMult(MAX_WAIT - 1, 1'b0);
    runDiv(0, 32'hFFFF_FFFF);
    runDiv(-1, 32'h5);
    gap();

    // Simultaneous starts, with divide requests repeated while busy
    d0 = doneCnt; ds0 = divStartCnt;
    runMult(5, 1'b1);
    gap();
    gap();
    check("both done pulses", doneCnt - d0, 1);
    check("both div launches", divStartCnt - ds0, 0);

    // Reset in the middle of M_WAIT aborts without a done pulse
    d0 = doneCnt; h0 = hiCnt;
    step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, E_IDLE);
    step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, E_MLAUNCH);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, E_MWAIT);
    reset = 1'b1;
    #1;
    check("outputs at reset", {mult_start, div_start, hilo_sel, hi_write, lo_write,
                               busy, done, div_zero, timeout}, 32'd0);
    step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b1, E_IDLE);
    step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b1, E_IDLE);
    step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0, E_IDLE);
    for (int i = 0; i < 4; i++) gap();
    check("abort done pulses", doneCnt - d0, 0);
    check("abort hi writes", hiCnt - h0, 0);
    d0 = doneCnt;
    runMult(3, 1'b0);
    gap();
    check("post-abort done pulses", doneCnt - d0, 1);

    // Randomized operation mix
    for (int k = 0; k < 60; k++) begin
      int kind, n, g;
      kind = $urandom_range(0, 3);
      n = rnd(8) ? -1 : $urandom_range(0, 40);
      case (kind)
        0:       runMult(n, rnd(4));
        1:       runDiv(n, $urandom | 32'h1);
        2:       runDivZero();
        default: runDiv(n, 32'h8000_0000);
      endcase
      g = $urandom_range(0, 3);
      for (int j = 0; j < g; j++) gap();
    end
    gap();
    gap();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Sequences the iterative multiplier and divider engines that feed the High/Low registers. Sits between the main control FSM and those engines.
- Takes a one-cycle start command, launches the selected engine and waits for its completion flag (with a timeout). Then drives the High/Low source select and load strobes, and returns a done pulse.
- Detects divide-by-zero before launching the divider.

Parameters:
MAX_WAIT, 64, maximum cycles spent waiting for an engine done flag before timeout
CW, $clog2(MAX_WAIT+1), wait-counter width (derived; not overridden)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
start_mult  in  1  one-cycle request from control FSM: run MULT/MULTU
start_div  in  1  one-cycle request from control FSM: run DIV/DIVU
divisor  in  32  B-register value, checked for zero when start_div is sampled
mult_start  out  1  one-cycle launch pulse to multiplier engine
mult_done  in  1  multiplier result valid
div_start  out  1  one-cycle launch pulse to divider engine
div_done  in  1  divider result valid
hilo_sel  out  1  High/Low source mux select: 1 = multiplier, 0 = divider
hi_write  out  1  High register load strobe
lo_write  out  1  Low register load strobe
busy  out  1  high in every state except IDLE
done  out  1  one-cycle completion pulse to control FSM
div_zero  out  1  high together with done when a divide had divisor == 0
timeout  out  1  high together with done when an engine exceeded MAX_WAIT

Behaviour:
- Moore FSM. All outputs decode from registered state only.
- Async reset forces state IDLE and wait counter 0. Every output is 0 while reset is high and in the cycle after release.
- Reset asserted mid-operation aborts immediately. No HI/LO write and no done pulse follow.
- States: IDLE, M_LAUNCH, M_WAIT, D_LAUNCH, D_WAIT, WB, FIN, DZ, TO.
- IDLE:
  - start_mult=1 -> M_LAUNCH. Multiply has priority when both starts are high; the divide request is dropped.
  - Else start_div=1 and divisor==0 -> DZ.
  - Else start_div=1 -> D_LAUNCH.
- M_LAUNCH / D_LAUNCH: mult_start / div_start = 1 for exactly this cycle. Clear counter. Go to M_WAIT / D_WAIT.
- M_WAIT / D_WAIT:
  - Matching done flag sampled high -> WB.
  - Else, if counter == MAX_WAIT-1 -> TO.
  - Else counter += 1.
  - The non-matching engine's done flag is ignored.
- WB: hi_write = lo_write = 1 for one cycle. hilo_sel = 1 for a multiply, 0 for a divide. Go to FIN.
- FIN: done = 1. Go to IDLE.
- DZ: done = div_zero = 1 for one cycle. No engine launch, no HI/LO write. Go to IDLE.
- TO: done = timeout = 1 for one cycle. No HI/LO write. Go to IDLE.
- hilo_sel is 1 in M_LAUNCH, M_WAIT and multiply WB. It is 0 in all other states. An op-type flag, captured at start acceptance, selects the WB value.
- start_* pulses arriving while busy=1 are ignored, not queued.
- Engine done flags seen in IDLE, LAUNCH, WB, FIN, DZ or TO are ignored.
- Timing, with start sampled at edge 0:
  - launch pulse in cycle 1; WAIT from cycle 2.
  - Done flag first sampled high at the edge ending WAIT cycle 2+n (n = 0..MAX_WAIT-1) gives write strobes in cycle 3+n and done in cycle 4+n.
  - Divide-by-zero: done in cycle 1.
  - Timeout: done in cycle 2+MAX_WAIT.
- Counter never exceeds MAX_WAIT-1; no wrap-around.
- Exactly one done pulse per accepted start.

Test Plan:
- Reset mid-M_WAIT (MAX_WAIT=64, mult_done never asserted): all outputs 0 immediately. No done pulse follows; next start_mult is accepted normally.
- start_mult pulse, mult_done asserted 32 cycles after mult_start: mult_start high 1 cycle, busy high 36 cycles total. WB shows hi_write=lo_write=1, hilo_sel=1; done 1 cycle later with div_zero=0, timeout=0.
- start_div with divisor=32'h00000007, div_done after 32 cycles: div_start 1 cycle. WB shows hilo_sel=0 and both writes high; done pulse follows, div_zero=0.
- start_div with divisor=32'h00000000: done=div_zero=1 in cycle 1. div_start, hi_write and lo_write never assert; busy high exactly 1 cycle.
- start_mult with mult_done held low (MAX_WAIT=64): done=timeout=1 at cycle 66 with no HI/LO write. Spurious div_done pulses during M_WAIT have no effect.
- start_mult and start_div high simultaneously, then start_div repeated while busy: only the multiply runs, exactly one done pulse, div_start never asserts.
